// File: rtl/av2_recon_frame_writer_if.sv
// Memory write port of the recon frame writer: the writer drives the request and memory drives ready.
interface av2_recon_frame_writer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128
) ();
   logic                  mem_valid;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
   modport slave  (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/av2_recon_frame_writer.sv
// Buffers recon beats in a FIFO and writes them to frame memory; a push reaches mem_valid 2 cycles later.
// Memory stalls fill the FIFO; the decoder cannot be stalled, so a push into a full FIFO is dropped and flagged.
module av2_recon_frame_writer #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] frame_base_i,
   input  logic [15:0]           frame_pixels_i,
   input  logic                  in_wr_en_i,
   input  logic [31:0]           in_addr_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  tile_done_i,
   av2_recon_frame_writer_if.master mem,
   output logic                  frame_done_o,
   output logic                  overflow_o,
   output logic [15:0]           beats_written_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [15:0]           pix_q, pix_d;
   logic [31:0]           last_addr_q, last_addr_d;
   logic                  last_vld_q, last_vld_d;
   logic                  ovf_q, ovf_d;
   logic [15:0]           bw_q, bw_d;
   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  empty, full, load, pop, hs, push_req, push;
   logic [ADDR_WIDTH-1:0] push_addr;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign load      = !valid_q || mem.mem_ready;
   assign pop       = load && !empty;
   assign hs        = valid_q && mem.mem_ready;
   assign push_req  = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && in_wr_en_i &&
                      (in_addr_i < {16'd0, pix_q}) &&
                      !(last_vld_q && (in_addr_i == last_addr_q));
   assign push      = push_req && (!full || pop);
   assign push_addr = base_q + ADDR_WIDTH'(in_addr_i);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      base_d      = base_q;
      pix_d       = pix_q;
      last_addr_d = last_addr_q;
      last_vld_d  = last_vld_q;
      ovf_d       = ovf_q;
      bw_d        = bw_q;
      valid_d     = valid_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if (start_i) begin
         // A restart abandons everything in flight, including an unaccepted request.
         state_d    = S_STREAM;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         base_d     = frame_base_i;
         pix_d      = frame_pixels_i;
         last_vld_d = 1'b0;
         ovf_d      = 1'b0;
         bw_d       = '0;
         valid_d    = 1'b0;
         addr_d     = '0;
         wdata_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE:   state_d = S_IDLE;
            S_STREAM: if (tile_done_i) state_d = S_DRAIN;
            S_DRAIN:  if (empty && !valid_q) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
         if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            last_addr_d = in_addr_i;
            last_vld_d  = 1'b1;
         end else if (push_req) begin
            ovf_d = 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (hs) bw_d = bw_q + 16'd1;
         if (load) begin
            valid_d = !empty;
            if (!empty) begin
               addr_d  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
               wdata_d = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !start_i) begin
         fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= push_addr;
         fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= in_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         base_q      <= '0;
         pix_q       <= '0;
         last_addr_q <= '0;
         last_vld_q  <= 1'b0;
         ovf_q       <= 1'b0;
         bw_q        <= '0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         base_q      <= base_d;
         pix_q       <= pix_d;
         last_addr_q <= last_addr_d;
         last_vld_q  <= last_vld_d;
         ovf_q       <= ovf_d;
         bw_q        <= bw_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign mem.mem_valid   = valid_q;
   assign mem.mem_addr    = addr_q;
   assign mem.mem_wdata   = wdata_q;
   assign frame_done_o    = (state_q == S_DONE);
   assign overflow_o      = ovf_q;
   assign beats_written_o = bw_q;
endmodule

// File: tb/tb_av2_recon_frame_writer.sv
// Bench for av2_recon_frame_writer: hand table, directed corner sequences, then random traffic vs a queue model.
module tb_av2_recon_frame_writer;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int DEPTH = 8;
   localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_DONE = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, wr, tile_done, ready;
   logic [31:0]   base, addr;
   logic [15:0]   pix;
   logic [DW-1:0] data;
   logic          frame_done, overflow;
   logic [15:0]   bw;

   av2_recon_frame_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();
   assign mem_if.mem_ready = ready;

   av2_recon_frame_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .frame_base_i(base), .frame_pixels_i(pix),
      .in_wr_en_i(wr), .in_addr_i(addr), .in_data_i(data), .tile_done_i(tile_done),
      .mem(mem_if), .frame_done_o(frame_done), .overflow_o(overflow), .beats_written_o(bw));

   typedef struct packed {logic [31:0] a; logic [DW-1:0] d;} beat_t;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: buffered beats as a queue plus the single output slot.
   beat_t       mq[$];
   beat_t       wr_log[$];
   int          m_st;
   logic        m_v, m_ovf, m_lv;
   beat_t       m_out;
   logic [15:0] m_bw, m_pix;
   logic [31:0] m_la, m_base;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_st = P_IDLE; m_v = 0; m_out = '0; m_ovf = 0; m_bw = 0;
      m_lv = 0; m_la = 0; m_base = 0; m_pix = 0;
   endtask

   task automatic model_edge();
      int osz;
      logic old_v, pop_ok, pt, acc;
      beat_t b;
      if (start) begin
         mq.delete();
         m_st = P_STREAM; m_v = 0; m_out = '0; m_ovf = 0; m_bw = 0;
         m_lv = 0; m_base = base; m_pix = pix;
         return;
      end
      osz    = mq.size();
      old_v  = m_v;
      pop_ok = (!m_v || ready) && (osz > 0);
      pt     = (m_st == P_STREAM || m_st == P_DRAIN) && wr && (addr < {16'd0, m_pix}) &&
               !(m_lv && addr == m_la);
      acc    = pt && (osz < DEPTH || pop_ok);
      if (pt && !acc) m_ovf = 1;
      if (m_v && ready) m_bw = m_bw + 16'd1;
      if (!m_v || ready) begin
         if (pop_ok) begin
            m_out = mq.pop_front();
            m_v = 1;
         end else begin
            m_v = 0;
         end
      end
      if (acc) begin
         b.a = m_base + addr;
         b.d = data;
         mq.push_back(b);
         m_lv = 1;
         m_la = addr;
      end
      case (m_st)
         P_STREAM: if (tile_done) m_st = P_DRAIN;
         P_DRAIN:  if (osz == 0 && !old_v) m_st = P_DONE;
         P_DONE:   m_st = P_IDLE;
         default:  m_st = m_st;
      endcase
   endtask

   task automatic step();
      beat_t b;
      if (mem_if.mem_valid && ready) begin
         b.a = mem_if.mem_addr;
         b.d = mem_if.mem_wdata;
         wr_log.push_back(b);
      end
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      chk("mem_valid", mem_if.mem_valid, m_v);
      if (m_v) begin
         chk("mem_addr", mem_if.mem_addr, m_out.a);
         chk("mem_wdata", mem_if.mem_wdata, m_out.d);
      end
      chk("frame_done", frame_done, m_st == P_DONE);
      chk("overflow", overflow, m_ovf);
      chk("beats_written", bw, m_bw);
   endtask

   task automatic idle_in();
      start = 0; wr = 0; tile_done = 0;
   endtask

   typedef struct {
      logic st; logic w; logic [31:0] a; logic td; logic rdy;
      logic ev; logic [31:0] ea; logic ed; logic [15:0] ebw;
   } vec_t;
   vec_t vt[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] d0;
      int cnt, hs3, done_i, done_cnt, n_prev, rp, done_seen;
      logic [31:0] prev_a;

      rst_n = 0; ready = 0; base = 0; pix = 0; addr = 0; data = '0;
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", mem_if.mem_valid, 0);
      chk("rst_addr", mem_if.mem_addr, 0);
      chk("rst_wdata", mem_if.mem_wdata, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_bw", bw, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      @(posedge clk);
      #1;

      // Frame of 4 beats, duplicated final beat, out-of-range beat, push while idle.
      vt[0]  = '{1, 0, 0,  0, 1, 0, 32'h0,    0, 0};
      vt[1]  = '{0, 1, 0,  0, 1, 0, 32'h0,    0, 0};
      vt[2]  = '{0, 1, 16, 0, 1, 1, 32'h1000, 0, 0};
      vt[3]  = '{0, 1, 32, 0, 1, 1, 32'h1010, 0, 1};
      vt[4]  = '{0, 1, 48, 0, 1, 1, 32'h1020, 0, 2};
      vt[5]  = '{0, 1, 48, 1, 1, 1, 32'h1030, 0, 3};
      vt[6]  = '{0, 1, 64, 0, 1, 0, 32'h0,    0, 4};
      vt[7]  = '{0, 0, 0,  0, 1, 0, 32'h0,    1, 4};
      vt[8]  = '{0, 0, 0,  0, 1, 0, 32'h0,    0, 4};
      vt[9]  = '{0, 1, 0,  0, 1, 0, 32'h0,    0, 4};
      vt[10] = '{0, 0, 0,  0, 1, 0, 32'h0,    0, 4};
      vt[11] = '{0, 0, 0,  0, 1, 0, 32'h0,    0, 4};
      base = 32'h1000; pix = 16'd64;
      wr_log.delete();
      for (int i = 0; i < 12; i++) begin
         start = vt[i].st; wr = vt[i].w; addr = vt[i].a; tile_done = vt[i].td; ready = vt[i].rdy;
         data = {4{vt[i].a ^ 32'hC0DE_0000}};
         step();
         chk($sformatf("tbl%0d_valid", i), mem_if.mem_valid, vt[i].ev);
         if (vt[i].ev) chk($sformatf("tbl%0d_addr", i), mem_if.mem_addr, vt[i].ea);
         chk($sformatf("tbl%0d_done", i), frame_done, vt[i].ed);
         chk($sformatf("tbl%0d_bw", i), bw, vt[i].ebw);
         chk($sformatf("tbl%0d_ovf", i), overflow, 0);
      end
      idle_in();
      cnt = 0;
      foreach (wr_log[i]) if (wr_log[i].a == 32'h1030) cnt++;
      chk("dup_single_write", cnt, 1);
      chk("tbl_total_writes", wr_log.size(), 4);

      // Overflow: 10 beats into a stalled memory.
      start = 1; base = 32'h2000; pix = 16'd1000; ready = 0;
      step();
      start = 0;
      for (int i = 0; i < 10; i++) begin
         wr = 1; addr = i * 16; data = {$urandom, $urandom, $urandom, $urandom};
         if (i == 0) d0 = data;
         step();
         check_model();
      end
      wr = 0;
      chk("ovf_set", overflow, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", mem_if.mem_valid, 1);
         chk("stall_addr", mem_if.mem_addr, 32'h2000);
         chk("stall_data", mem_if.mem_wdata, d0);
      end
      ready = 1;
      wr_log.delete();
      for (int i = 0; i < 15; i++) begin
         step();
         check_model();
      end
      chk("ovf_retained", wr_log.size(), 9);
      for (int i = 0; i < 9 && i < wr_log.size(); i++)
         chk("ovf_order", wr_log[i].a, 32'h2000 + 32'(i * 16));

      // Drain with 3 buffered beats under a toggling ready.
      start = 1; base = 32'h4000; pix = 16'd256; ready = 0;
      step();
      start = 0;
      for (int i = 0; i < 3; i++) begin
         wr = 1; addr = i * 16; data = {4{$urandom}};
         step();
      end
      wr = 0; tile_done = 1;
      step();
      tile_done = 0;
      wr_log.delete();
      hs3 = -10; done_i = -1; done_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         ready = i[0];
         n_prev = wr_log.size();
         step();
         check_model();
         if (wr_log.size() == 3 && n_prev == 2) hs3 = i;
         if (frame_done) begin
            done_cnt++;
            done_i = i;
         end
      end
      chk("drain_done_count", done_cnt, 1);
      chk("drain_done_timing", done_i, hs3 + 1);

      // Reset while draining a full, overflowed buffer.
      start = 1; base = 32'h6000; pix = 16'd500; ready = 0;
      step();
      start = 0;
      for (int i = 0; i < 10; i++) begin
         wr = 1; addr = 100 + i; data = {4{$urandom}};
         step();
      end
      wr = 0; tile_done = 1;
      step();
      tile_done = 0;
      step();
      #2;
      rst_n = 0;
      #1;
      chk("arst_valid", mem_if.mem_valid, 0);
      chk("arst_addr", mem_if.mem_addr, 0);
      chk("arst_wdata", mem_if.mem_wdata, 0);
      chk("arst_done", frame_done, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_bw", bw, 0);
      model_reset();
      ready = 1;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("post_rst_valid", mem_if.mem_valid, 0);
         check_model();
      end

      // Restart mid-stream with buffered beats, overflow and a written count pending.
      start = 1; base = 32'h3000; pix = 16'd1000; ready = 1;
      step();
      start = 0;
      wr = 1; addr = 500; data = {4{$urandom}};
      step();
      wr = 0;
      repeat (4) step();
      ready = 0;
      for (int i = 0; i < 10; i++) begin
         wr = 1; addr = (i == 8) ? 0 : (i < 8 ? (i + 1) * 16 : 144); data = {4{$urandom}};
         step();
      end
      wr = 0;
      chk("pre_restart_ovf", overflow, 1);
      chk("pre_restart_bw", bw, 1);
      start = 1; base = 32'h5000; pix = 16'd32;
      step();
      start = 0;
      chk("restart_valid", mem_if.mem_valid, 0);
      chk("restart_ovf", overflow, 0);
      chk("restart_bw", bw, 0);
      wr_log.delete();
      ready = 1; wr = 1; addr = 0; data = {4{32'hFACE_0001}}; d0 = data;
      step();
      wr = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         check_model();
      end
      chk("restart_writes", wr_log.size(), 1);
      if (wr_log.size() > 0) begin
         chk("restart_addr", wr_log[0].a, 32'h5000);
         chk("restart_data", wr_log[0].d, d0);
      end

      // Random traffic against the model; the first frame base wraps the address space.
      for (int f = 0; f < 2; f++) begin
         start = 1; base = (f == 0) ? 32'hFFFF_FF80 : $urandom; pix = 16'($urandom_range(300, 40));
         ready = 1;
         step();
         start = 0;
         check_model();
         prev_a = 0; rp = 60; done_seen = 0;
         for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) rp = (i % 150 == 0) ? 20 : ((i % 100 == 0) ? 95 : 60);
            wr = ($urandom_range(9, 0) < 6);
            addr = ($urandom_range(3, 0) == 0) ? prev_a : 32'($urandom_range(int'(pix) + 32, 0));
            prev_a = addr;
            data = {$urandom, $urandom, $urandom, $urandom};
            ready = ($urandom_range(99, 0) < rp);
            tile_done = (i == 350);
            step();
            check_model();
            if (frame_done) done_seen++;
         end
         idle_in();
         for (int i = 0; i < 100; i++) begin
            ready = ($urandom_range(3, 0) != 0);
            step();
            check_model();
            if (frame_done) done_seen++;
         end
         chk("rand_done_seen", done_seen, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
